// File: rtl/imem_arbiter.sv
// Two-requester read arbiter (fetch F, load D) in front of a single-ported memory, with registered responses.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin; the default build is fixed priority (D beats F).
module imem_arbiter #(
  parameter int DEPTH  = 128,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [AW-1:0]     f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DW-1:0]     f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [AW-1:0]     d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              d_err,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy,
  output logic [WAIT_W-1:0] f_wait_cnt
);

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  port_e         last;
  logic          d_wins;
  logic          oor;
  logic [DW-1:0] cap_data;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    mem_addr = '0;
`ifdef ARB_ROUND_ROBIN_EN
    d_wins   = (last == PORT_F);
`else
    // last is still tracked in this build but never changes the outcome.
    d_wins   = (last == PORT_F) || 1'b1;
`endif
    // Grants are suppressed combinationally while reset is asserted.
    if (rst_n) begin
      if (f_req && (!d_req || !d_wins)) begin
        f_gnt    = 1'b1;
        mem_addr = f_addr;
      end else if (d_req) begin
        d_gnt    = 1'b1;
        mem_addr = d_addr;
      end
    end
  end

  assign oor      = (mem_addr >= AW'(DEPTH));
  assign cap_data = oor ? '0 : mem_rdata;
  assign busy     = f_rvalid | d_rvalid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      f_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      f_rvalid <= f_gnt;
      d_rvalid <= d_gnt;
      if (f_gnt) begin
        f_rdata <= cap_data;
        f_err   <= oor;
      end
      if (d_gnt) begin
        d_rdata <= cap_data;
        d_err   <= oor;
      end
    end
  end

  // Fairness pointer and the saturating count of cycles F has been kept waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= PORT_D;
      f_wait_cnt <= '0;
    end else begin
      if (f_gnt) begin
        last <= PORT_F;
      end else if (d_gnt) begin
        last <= PORT_D;
      end
      if (f_req && !f_gnt) begin
        if (f_wait_cnt != '1) begin
          f_wait_cnt <= f_wait_cnt + 1'b1;
        end
      end else begin
        f_wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed corner cases plus random traffic against a high-level model.
// Expected arbitration follows ARB_ROUND_ROBIN_EN the same way the design does.
module tb_imem_arbiter;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req;
  logic [31:0] f_addr, d_addr;
  logic        f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err, busy;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_rdata;
  logic [7:0]  f_wait_cnt;

  logic [31:0] mem [DEPTH];

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t q [2][$];
  int    cyc     = 0;
  int    n_check = 0;
  int    n_fail  = 0;

  // Model state: who won last (1 = D), whether a grant happened last cycle, F wait count.
  bit    m_last = 1'b1;
  bit    m_busy = 1'b0;
  int    m_wcnt = 0;

  imem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .f_wait_cnt(f_wait_cnt)
  );

  // Memory array; out-of-range reads return junk that the arbiter must not pass through.
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[6:0]] : 32'hBADC_0FFE;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbitration checker: predicts grants from the rules and queues the expected response.
  always @(negedge clk) begin
    bit          ef, ed;
    logic [31:0] ea;
    if (!rst_n) begin
      check("rst_f_gnt", f_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_wait_cnt", f_wait_cnt, 0);
      m_last = 1'b1;
      m_busy = 1'b0;
      m_wcnt = 0;
    end else begin
      ef = 1'b0;
      ed = 1'b0;
      if (f_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m_last) ef = 1'b1;
        else        ed = 1'b1;
`else
        ed = 1'b1;
`endif
      end else if (f_req) begin
        ef = 1'b1;
      end else if (d_req) begin
        ed = 1'b1;
      end
      ea = ef ? f_addr : (ed ? d_addr : 32'd0);
      check("f_gnt", f_gnt, ef);
      check("d_gnt", d_gnt, ed);
      check("mem_addr", mem_addr, ea);
      check("busy", busy, m_busy);
      check("f_wait_cnt", f_wait_cnt, m_wcnt);
      if (ef || ed) begin
        resp_t r;
        r.cyc  = cyc + 1;
        r.data = (ea < DEPTH) ? mem[ea[6:0]] : 32'd0;
        r.err  = (ea >= DEPTH);
        q[ed ? 1 : 0].push_back(r);
        m_last = ed;
      end
      m_busy = ef || ed;
      m_wcnt = (f_req && !ef) ? ((m_wcnt == 255) ? 255 : m_wcnt + 1) : 0;
    end
  end

  // Response monitor: pops the scoreboard whenever a port presents rvalid.
  always @(negedge clk) begin
    logic        rv [2];
    logic [31:0] rd [2];
    logic        er [2];
    rv[0] = f_rvalid; rd[0] = f_rdata; er[0] = f_err;
    rv[1] = d_rvalid; rd[1] = d_rdata; er[1] = d_err;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        check(p ? "rst_d_rvalid" : "rst_f_rvalid", rv[p], 0);
        check(p ? "rst_d_rdata" : "rst_f_rdata", rd[p], 0);
        check(p ? "rst_d_err" : "rst_f_err", er[p], 0);
        q[p].delete();
      end
      check("rst_busy", busy, 0);
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rv[p]) begin
          if (q[p].size() == 0) begin
            check(p ? "d_rvalid_unexpected" : "f_rvalid_unexpected", 1, 0);
          end else begin
            resp_t r;
            r = q[p].pop_front();
            check(p ? "d_resp_cycle" : "f_resp_cycle", cyc, r.cyc);
            check(p ? "d_rdata" : "f_rdata", rd[p], r.data);
            check(p ? "d_err" : "f_err", er[p], r.err);
          end
        end else if (q[p].size() != 0 && q[p][0].cyc <= cyc) begin
          check(p ? "d_rvalid_missing" : "f_rvalid_missing", 0, 1);
          void'(q[p].pop_front());
        end
      end
    end
  end

  // Sets this cycle's inputs, then moves to just after the next rising edge.
  task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da);
    f_req  = fr;
    f_addr = fa;
    d_req  = dr;
    d_addr = da;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fg, dg;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[3] = 32'h8C12_3456;

    // Reset held with both requesters active; grants must stay low.
    rst_n  = 1'b0;
    f_req  = 1'b1; f_addr = 32'd1;
    d_req  = 1'b1; d_addr = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Continuous contention for six cycles.
    repeat (6) drive(1'b1, 32'd1, 1'b1, 32'd5);
    drive(1'b0, 32'd0, 1'b0, 32'd0);

    // Single fetch, range boundaries and a contested out-of-range read.
    drive(1'b1, 32'd3, 1'b0, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 32'd128);
    drive(1'b0, 32'd0, 1'b1, 32'd2);
    drive(1'b1, 32'd127, 1'b0, 32'd0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    drive(1'b1, 32'd3, 1'b1, 32'd128);
    drive(1'b1, 32'd3, 1'b1, 32'd128);
    drive(1'b0, 32'd0, 1'b0, 32'd0);

    // Long contention: the fetch wait counter must saturate under fixed priority.
    repeat (300) drive(1'b1, 32'd7, 1'b1, 32'd9);
    drive(1'b1, 32'd7, 1'b0, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd0);

    // Random traffic; each requester holds req and addr until granted.
    f_req = 1'b0;
    d_req = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      fg = f_gnt;
      dg = d_gnt;
      @(posedge clk);
      #1;
      if (!f_req || fg) begin
        f_req  = 1'($urandom_range(0, 1));
        f_addr = 32'($urandom_range(0, 140));
      end
      if (!d_req || dg) begin
        d_req  = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 140));
      end
    end
    drive(1'b0, 32'd0, 1'b0, 32'd0);

    // Reset pulsed while a fetch response is in flight; it must be dropped.
    drive(1'b1, 32'd3, 1'b0, 32'd0);
    f_req = 1'b0;
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) drive(1'b0, 32'd0, 1'b0, 32'd0);

    // First contested cycle after the second reset.
    drive(1'b1, 32'd10, 1'b1, 32'd11);
    repeat (3) drive(1'b0, 32'd0, 1'b0, 32'd0);

    check("f_queue_drained", q[0].size(), 0);
    check("d_queue_drained", q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
